// File: rtl/hh_spike_detector.sv
// Spike detector for the linear Hodgkin-Huxley neuron core.
// It watches the signed membrane-potential sample stream for upward threshold
// crossings. After each spike it ignores a refractory run of samples, then
// waits for the potential to fall below threshold - hyst before it re-arms.
// Each spike is emitted as a valid/ready event that carries a sequence number
// and the inter-spike interval, measured in samples.
module hh_spike_detector #(
    parameter int V_W   = 16,
    parameter int ISI_W = 16,
    parameter int SEQ_W = 16,
    parameter int REF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [V_W-1:0]   v_in,
    input  logic             v_valid,
    input  logic [V_W-1:0]   threshold,
    input  logic [V_W-1:0]   hyst,
    input  logic [REF_W-1:0] refrac,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [ISI_W-1:0] spike_isi,
    output logic [SEQ_W-1:0] spike_seq,
    output logic             spike_pulse,
    output logic             overflow,
    output logic             armed
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_REFRAC = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [ISI_W-1:0]   isi_cnt_q, isi_cnt_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic               spike_valid_q, spike_valid_d;
    logic [ISI_W-1:0]   spike_isi_q, spike_isi_d;
    logic [SEQ_W-1:0]   spike_seq_q, spike_seq_d;
    logic               spike_pulse_q, spike_pulse_d;
    logic               overflow_q, overflow_d;
    logic               armed_q, armed_d;

    logic signed [V_W:0] rearm_level_s;
    logic signed [V_W:0] v_ext_s;
    logic [ISI_W-1:0]    isi_inc_s;
    logic [SEQ_W-1:0]    seq_inc_s;
    logic                spike_s;
    logic                load_s;

    // Next-state logic for the detector FSM, the counters and the event register.
    always_comb begin
        // The re-arm level is one bit wider than a sample, so threshold - hyst never wraps.
        rearm_level_s = $signed({threshold[V_W-1], threshold}) - $signed({1'b0, hyst});
        v_ext_s       = $signed({v_in[V_W-1], v_in});
        isi_inc_s     = (isi_cnt_q == {ISI_W{1'b1}}) ? isi_cnt_q : isi_cnt_q + {{(ISI_W-1){1'b0}}, 1'b1};
        seq_inc_s     = seq_cnt_q + {{(SEQ_W-1){1'b0}}, 1'b1};
        spike_s       = v_valid && (state_q == ST_ARMED) && ($signed(v_in) >= $signed(threshold));
        load_s        = spike_s && (!spike_valid_q || spike_ready);

        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        case (state_q)
            ST_ARMED: begin
                if (spike_s) begin
                    if (refrac == {REF_W{1'b0}}) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d   = ST_REFRAC;
                        ref_cnt_d = refrac;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_REFRAC: begin
                if (v_valid) begin
                    if (ref_cnt_q <= {{(REF_W-1){1'b0}}, 1'b1}) begin
                        state_d   = ST_WAIT;
                        ref_cnt_d = {REF_W{1'b0}};
                    end else begin
                        ref_cnt_d = ref_cnt_q - {{(REF_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    ref_cnt_d = ref_cnt_q;
                end
            end
            ST_WAIT: begin
                if (v_valid && (v_ext_s < rearm_level_s)) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d   = ST_ARMED;
                ref_cnt_d = {REF_W{1'b0}};
            end
        endcase

        // The interval counter restarts on every spike, including spikes whose event is dropped.
        if (v_valid) begin
            isi_cnt_d = spike_s ? {ISI_W{1'b0}} : isi_inc_s;
        end else begin
            isi_cnt_d = isi_cnt_q;
        end
        seq_cnt_d = spike_s ? seq_inc_s : seq_cnt_q;

        if (load_s) begin
            spike_valid_d = 1'b1;
            spike_isi_d   = isi_inc_s;
            spike_seq_d   = seq_inc_s;
        end else if (spike_ready) begin
            spike_valid_d = 1'b0;
            spike_isi_d   = spike_isi_q;
            spike_seq_d   = spike_seq_q;
        end else begin
            spike_valid_d = spike_valid_q;
            spike_isi_d   = spike_isi_q;
            spike_seq_d   = spike_seq_q;
        end

        overflow_d    = overflow_q | (spike_s && spike_valid_q && !spike_ready);
        spike_pulse_d = spike_s;
        armed_d       = (state_d == ST_ARMED);
    end

    // State and output registers; reset discards any held event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ARMED;
            ref_cnt_q     <= {REF_W{1'b0}};
            isi_cnt_q     <= {ISI_W{1'b0}};
            seq_cnt_q     <= {SEQ_W{1'b0}};
            spike_valid_q <= 1'b0;
            spike_isi_q   <= {ISI_W{1'b0}};
            spike_seq_q   <= {SEQ_W{1'b0}};
            spike_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
            armed_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            isi_cnt_q     <= isi_cnt_d;
            seq_cnt_q     <= seq_cnt_d;
            spike_valid_q <= spike_valid_d;
            spike_isi_q   <= spike_isi_d;
            spike_seq_q   <= spike_seq_d;
            spike_pulse_q <= spike_pulse_d;
            overflow_q    <= overflow_d;
            armed_q       <= armed_d;
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_isi   = spike_isi_q;
    assign spike_seq   = spike_seq_q;
    assign spike_pulse = spike_pulse_q;
    assign overflow    = overflow_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_hh_spike_detector.sv
// Scoreboard bench for hh_spike_detector: directed sample sequences push
// hand-computed events into a queue; a monitor pops and compares on each handshake.
module tb_hh_spike_detector;

    localparam int V_W   = 16;
    localparam int ISI_W = 4;
    localparam int SEQ_W = 16;
    localparam int REF_W = 8;

    logic             clk;
    logic             reset;
    logic [V_W-1:0]   v_in;
    logic             v_valid;
    logic [V_W-1:0]   threshold;
    logic [V_W-1:0]   hyst;
    logic [REF_W-1:0] refrac;
    logic             spike_valid;
    logic             spike_ready;
    logic [ISI_W-1:0] spike_isi;
    logic [SEQ_W-1:0] spike_seq;
    logic             spike_pulse;
    logic             overflow;
    logic             armed;

    typedef struct packed {
        logic [ISI_W-1:0] isi;
        logic [SEQ_W-1:0] seq;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec     = 0;
    int  n_err     = 0;
    int  pulse_cnt = 0;

    hh_spike_detector #(.V_W(V_W), .ISI_W(ISI_W), .SEQ_W(SEQ_W), .REF_W(REF_W)) dut (
        .clk(clk), .reset(reset), .v_in(v_in), .v_valid(v_valid),
        .threshold(threshold), .hyst(hyst), .refrac(refrac),
        .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_isi(spike_isi), .spike_seq(spike_seq),
        .spike_pulse(spike_pulse), .overflow(overflow), .armed(armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: count strobes, pop and compare an expected event on every handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (spike_pulse) pulse_cnt++;
            if (spike_valid && spike_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got isi=%0d seq=%0d, expected none", spike_isi, spike_seq);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("ev_isi", int'(spike_isi), int'(e.isi));
                    check("ev_seq", int'(spike_seq), int'(e.seq));
                end
            end
        end
    end

    task automatic expect_ev(input int isi, input int seq);
        ev_t e;
        e.isi = ISI_W'(isi);
        e.seq = SEQ_W'(seq);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic signed [V_W-1:0] v);
        v_in    = v;
        v_valid = 1'b1;
        @(posedge clk);
        #1;
        v_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        v_valid     = 1'b0;
        v_in        = 16'sd0;
        threshold   = 16'sd0;
        hyst        = 16'd10;
        refrac      = 8'd3;
        spike_ready = 1'b1;
        idle(2);
        reset = 1'b0;

        // Reset state
        check("rst_valid", spike_valid, 0);
        check("rst_isi", spike_isi, 0);
        check("rst_seq", spike_seq, 0);
        check("rst_pulse", spike_pulse, 0);
        check("rst_overflow", overflow, 0);
        check("rst_armed", armed, 1);

        // Basic crossing with refractory window
        send(-16'sd65);
        send(-16'sd40);
        expect_ev(3, 1);
        send(16'sd5);
        check("t1_pulse", spike_pulse, 1);
        check("t1_armed_lo", armed, 0);
        send(16'sd20);
        check("t1_pulse_one", spike_pulse, 0);
        send(16'sd30);
        send(-16'sd20);
        check("t1_wait", armed, 0);
        send(-16'sd70);
        check("t1_rearm", armed, 1);
        expect_ev(5, 2);
        send(16'sd10);
        drain("t1_drain");

        // Hysteresis with refrac = 0
        refrac = 8'd0;
        do_reset();
        expect_ev(1, 1);
        send(16'sd5);
        send(-16'sd5);
        send(16'sd5);
        check("t2_no_rearm", armed, 0);
        check("t2_no_pulse", spike_pulse, 0);
        send(-16'sd15);
        check("t2_rearm", armed, 1);
        expect_ev(4, 2);
        send(16'sd5);
        drain("t2_drain");

        // Backpressure, drop and simultaneous consume+load
        do_reset();
        spike_ready = 1'b0;
        expect_ev(1, 1);
        send(16'sd5);
        send(-16'sd15);
        send(16'sd5);
        check("t3_valid", spike_valid, 1);
        check("t3_hold_seq", spike_seq, 1);
        check("t3_hold_isi", spike_isi, 1);
        check("t3_overflow", overflow, 1);
        send(-16'sd15);
        expect_ev(2, 3);
        spike_ready = 1'b1;
        send(16'sd5);
        spike_ready = 1'b0;
        check("t3_new_valid", spike_valid, 1);
        check("t3_new_seq", spike_seq, 3);
        check("t3_new_isi", spike_isi, 2);
        check("t3_overflow_sticky", overflow, 1);
        spike_ready = 1'b1;
        drain("t3_drain");

        // ISI saturation at 4 bits
        do_reset();
        repeat (20) send(-16'sd100);
        expect_ev(15, 1);
        send(16'sd5);
        drain("t4_drain");

        // Arithmetic edges
        threshold = 16'h8000;
        hyst      = 16'd100;
        do_reset();
        expect_ev(1, 1);
        send(-16'sd32768);
        repeat (5) send(-16'sd32768);
        check("t5_never_rearm", armed, 0);
        drain("t5a_drain");
        threshold = 16'h7FFF;
        hyst      = 16'd0;
        do_reset();
        send(16'sd32766);
        check("t5_below_max", spike_pulse, 0);
        expect_ev(2, 1);
        send(16'sd32767);
        check("t5_max_spike", spike_pulse, 1);
        drain("t5b_drain");

        // Reset during refractory with a held event, then v_valid gaps
        threshold   = 16'sd0;
        hyst        = 16'd10;
        refrac      = 8'd5;
        do_reset();
        spike_ready = 1'b0;
        send(16'sd5);
        send(-16'sd50);
        send(-16'sd50);
        check("t6_held", spike_valid, 1);
        do_reset();
        check("t6_rst_valid", spike_valid, 0);
        check("t6_rst_overflow", overflow, 0);
        check("t6_rst_armed", armed, 1);
        check("t6_rst_seq", spike_seq, 0);
        spike_ready = 1'b1;
        refrac      = 8'd2;
        expect_ev(1, 1);
        send(16'sd10);
        idle(5);
        send(-16'sd50);
        idle(3);
        send(-16'sd50);
        check("t6_gap_refrac", armed, 0);
        idle(2);
        send(-16'sd50);
        check("t6_rearm", armed, 1);
        expect_ev(4, 2);
        send(16'sd10);
        drain("t6_drain");

        check("pulse_total", pulse_cnt, 13);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hh_spike_detector.md
Name: hh_spike_detector

Overview:
Downstream stage of the linear Hodgkin-Huxley neuron core. It consumes the core's signed 16-bit membrane-potential sample stream (one sample per v_valid strobe) and detects action potentials using an upward threshold crossing, a refractory window and hysteresis re-arming. Each detected spike is emitted as an event carrying a sequence number and the inter-spike interval (ISI, in samples) over a valid/ready handshake toward the readout/IO logic.

Parameters:
V_W, 16, membrane-potential sample width (signed, same units as core output, mV integer)
ISI_W, 16, width of ISI counter and ISI field (saturating)
SEQ_W, 16, width of spike sequence counter (wrapping)
REF_W, 8, width of refractory-length input

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
v_in  in  V_W  signed membrane potential sample from neuron core
v_valid  in  1  v_in valid this cycle; no backpressure, sample always accepted
threshold  in  V_W  signed spike threshold; sampled every cycle
hyst  in  V_W  unsigned hysteresis; re-arm level = threshold - hyst
refrac  in  REF_W  number of valid samples ignored after a spike
spike_valid  out  1  event register holds an unconsumed event
spike_ready  in  1  consumer accepts event
spike_isi  out  ISI_W  ISI of held event, in samples
spike_seq  out  SEQ_W  sequence number of held event (first spike = 1)
spike_pulse  out  1  one-cycle strobe per detected spike, independent of handshake
overflow  out  1  sticky: an event was dropped
armed  out  1  high when FSM in ARMED

Behaviour:
- Reset (synchronous, has priority over everything): state=ARMED; spike_valid=0, spike_isi=0, spike_seq=0, spike_pulse=0, overflow=0, armed=1; internal isi_cnt=0, seq_cnt=0, ref_cnt=0. Reset mid-event discards held event.
- All FSM and counter updates occur only on cycles with v_valid=1, except handshake and spike_pulse clearing.
- FSM states:
  ARMED: v_valid && v_in >= threshold (signed compare) -> spike detected; next = REFRACTORY with ref_cnt=refrac, or WAIT_REARM if refrac==0.
  REFRACTORY: each v_valid sample decrements ref_cnt; the sample that takes ref_cnt 1->0 moves to WAIT_REARM. Exactly refrac samples are ignored after the spike sample.
  WAIT_REARM: v_valid && v_in < rearm_level -> ARMED. Rearming sample is never itself a spike.
- rearm_level computed at V_W+1 bits signed (threshold sign-extended minus hyst zero-extended); no wrap. If true result is below the most negative V_W value, rearm is impossible until inputs change.
- ISI: on each valid non-spike sample isi_cnt <= sat(isi_cnt+1). On spike sample reported ISI = sat(isi_cnt+1), then isi_cnt <= 0. Saturate at 2^ISI_W-1. First spike's ISI counts samples since reset. Back-to-back spike samples (refrac=0, hyst allows) give ISI=1.
- seq_cnt increments on every detected spike (wraps), including dropped ones; event carries post-increment value.
- Latency: spike on sample at cycle N -> spike_pulse=1 and event loaded (if accepted) at cycle N+1. spike_pulse high exactly one cycle per spike.
- Event register: load when spike detected and (spike_valid==0 or spike_ready==1) — simultaneous consume and new spike loads new event with no bubble, no drop. spike_valid clears on spike_ready with no new spike. Spike while spike_valid=1 and spike_ready=0: new event dropped, held event unchanged, overflow<=1 (cleared only by reset). spike_isi/spike_seq stable while spike_valid=1 && !spike_ready.
- threshold/hyst/refrac changes take effect on the next valid sample; ref_cnt already loaded is not reloaded.

Test Plan:
- Reset then threshold=0, hyst=10, refrac=3, spike_ready=1; samples -65,-40,5,20,30,-20,-70,10 -> spike_pulse after sample 3 (ISI=3, seq=1); samples 4-6 ignored/wait; -70 rearms; 10 -> spike ISI=5, seq=2.
- Hysteresis: threshold=0, hyst=10, refrac=0; samples 5,-5,5,-15,5 -> spikes on samples 1 and 5 only (ISI 1 then 4); -5 does not rearm.
- Backpressure: spike_ready=0, two spikes separated by rearm -> spike_valid stays high with seq=1 data unchanged, overflow=1, seq of next accepted event=3; raise ready one cycle with simultaneous spike -> new event loaded, no drop.
- ISI saturation with ISI_W=4: 20 below-threshold samples then spike -> spike_isi=15.
- Edge arithmetic: threshold=-32768, hyst=100 -> after first spike never rearms; threshold=32767, v_in=32767 -> spike detected (>= compare).
- Reset asserted during REFRACTORY with event held -> next cycle spike_valid=0, overflow=0, armed=1, seq restarts at 1; v_valid=0 gaps do not advance ISI or refractory count.
